muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter: MUL_CYCLES, default 2, number of execute cycles for MULT/MULTU (legal range 1..8).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 start_valid  input  1  E-stage holds a mult/div instruction; held high by the pipeline while stall_o is high.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 src_a  input  32  rs operand (dividend / multiplicand).
REQ-007 src_b  input  32  rt operand (divisor / multiplier).
REQ-008 flush  input  1  exception/ERET flush of E stage; cancels any operation.
REQ-009 stall_o  output  1  freezes F/D/E stages while an operation is in progress.
REQ-010 hilo_we  output  1  one-cycle pulse writing hi_o/lo_o into the HI/LO register.
REQ-011 hi_o  output  32  result high word (product[63:32] or remainder).
REQ-012 lo_o  output  32  result low word (product[31:0] or quotient).
REQ-013 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, DIV, DONE.
REQ-015 IDLE: start_valid=1 and flush=0 SHALL latch op/src_a/src_b, clear the 6-bit cycle counter, and go to MUL (op[1]=0) or DIV (op[1]=1).
REQ-016 stall_o SHALL be start_valid & ~flush in IDLE, 1 in MUL and DIV (unless flush=1), and 0 in DONE.
REQ-017 MUL SHALL compute the 64-bit product (signed for MULT, unsigned for MULTU) from the latched operands, remain for MUL_CYCLES cycles, then go to DONE.
REQ-018 DIV SHALL perform restoring radix-2 division, one quotient bit per cycle, on absolute values (DIV) or raw values (DIVU), remaining exactly 32 cycles, then go to DONE.
REQ-019 DIV sign fix-up SHALL make quotient negative iff src_a[31]^src_b[31] and remainder carry the sign of src_a.
REQ-020 Divide by zero SHALL NOT raise any flag; it SHALL complete in 32 cycles with the natural restoring result: DIVU lo=FFFFFFFF, hi=src_a; DIV lo/hi equal that result after REQ-019 sign fix-up.
REQ-021 Latency: accept at cycle T; DONE at T+MUL_CYCLES+1 (mult) or T+33 (div); stall_o high T..DONE-1.
REQ-022 DONE SHALL assert hilo_we for exactly one cycle with valid hi_o/lo_o, ignore start_valid, and return to IDLE.
REQ-023 hi_o/lo_o SHALL hold the last completed result until the next DONE.
REQ-024 flush=1 in any state SHALL force IDLE next cycle, suppress hilo_we that cycle, and keep hi_o/lo_o unchanged.
REQ-025 flush and start_valid in the same IDLE cycle: flush wins, nothing is accepted.
REQ-026 Operands SHALL be sampled only at acceptance; changes on src_a/src_b/op during MUL/DIV SHALL have no effect.

Reset
REQ-027 resetn=0 SHALL immediately force IDLE, counter=0, stall_o=0, hilo_we=0, busy_o=0, hi_o=0, lo_o=0, regardless of operation in progress.
REQ-028 After resetn deassertion, the first accept SHALL occur no earlier than the first rising edge with resetn=1.

Structure
REQ-029 Package muldiv_pkg SHALL hold the op encodings, the FSM state enum, and the constant DIV_CYCLES=32.
REQ-030 The iterative divider datapath (partial remainder, quotient shift register, one step per enable) SHALL be a sub-module named div_radix2; the FSM, counter, multiplier, and sign handling stay in muldiv_ctrl.

Verification
REQ-031 MULT src_a=FFFFFFFD (-3), src_b=00000005 -> hilo_we at T+3 (MUL_CYCLES=2), hi_o=FFFFFFFF, lo_o=FFFFFFF1.
REQ-032 DIVU src_a=100, src_b=7 -> stall_o high T..T+32, hilo_we at T+33, lo_o=14, hi_o=2.
REQ-033 DIV src_a=FFFFFFF9 (-7), src_b=2 -> lo_o=FFFFFFFD, hi_o=FFFFFFFF; DIV 7/-2 -> lo_o=FFFFFFFD, hi_o=00000001.
REQ-034 DIVU src_a=12345678, src_b=0 -> hilo_we at T+33, lo_o=FFFFFFFF, hi_o=12345678.
REQ-035 DIVU started, flush at T+10 -> stall_o low at T+10, IDLE at T+11, no hilo_we, hi_o/lo_o keep previous values; a new MULTU at T+12 completes normally.
REQ-036 resetn pulsed low at T+5 of a DIV -> all outputs 0 asynchronously; no hilo_we after release until a new accept.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide unit.
//   op_e            operation encoding seen on the op bus
//   muldiv_state_e  controller FSM states (also exported for debug)
//   DIV_CYCLES      iterations of the radix-2 divider (one quotient bit each)
//   CNT_W           width of the execute-cycle counter
//   abs_if / neg_if helpers for the signed DIV pre/post processing
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 6;

    // Magnitude of v when en is set and v is negative, v unchanged otherwise.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic en);
        return (en && v[31]) ? -v : v;
    endfunction

    // Two's-complement negate when en is set.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        return en ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: pipeline <-> multiply/divide unit connection.
//   master (pipeline E stage): start_valid, op, src_a, src_b, flush
//   slave  (muldiv_ctrl)     : stall_o, hilo_we, hi_o, lo_o, busy_o, state_dbg
//
// Handshake: start_valid is the request; stall_o is the inverse of ready.
// The pipeline holds start_valid and the operands steady while stall_o is
// high. A request is accepted on the rising edge where the unit is IDLE,
// start_valid=1 and flush=0. flush cancels whatever is in flight and always
// wins over start_valid.
interface muldiv_if;
    import muldiv_pkg::*;

    logic          start_valid;
    logic [1:0]    op;
    logic [31:0]   src_a;
    logic [31:0]   src_b;
    logic          flush;
    logic          stall_o;
    logic          hilo_we;
    logic [31:0]   hi_o;
    logic [31:0]   lo_o;
    logic          busy_o;
    muldiv_state_e state_dbg;

    modport master (
        output start_valid, op, src_a, src_b, flush,
        input  stall_o, hilo_we, hi_o, lo_o, busy_o, state_dbg
    );

    modport slave (
        input  start_valid, op, src_a, src_b, flush,
        output stall_o, hilo_we, hi_o, lo_o, busy_o, state_dbg
    );

endinterface

// File: rtl/div_radix2.sv
// div_radix2: iterative restoring radix-2 divider on unsigned 32-bit values.
//   clk, resetn : clock, async active-low reset
//   load        : capture dividend/divisor and clear the partial remainder
//   en          : perform one iteration (one quotient bit)
//   quotient    : quotient, valid after 32 enabled iterations
//   remainder   : remainder, valid after 32 enabled iterations
// A zero divisor needs no special case: every trial subtraction succeeds,
// giving quotient FFFFFFFF and remainder equal to the dividend.
module div_radix2 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [32:0] shifted;
    logic        ge;

    always_comb begin
        // quo_q doubles as the dividend shift register: its MSB feeds the
        // partial remainder while quotient bits enter from the bottom.
        shifted = {rem_q, quo_q[31]};
        ge      = (shifted >= {1'b0, dvsr_q});
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        if (load) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvsr_d = divisor;
        end else if (en) begin
            // When ge the difference is below the divisor, so 32 bits suffice.
            rem_d = ge ? (shifted[31:0] - dvsr_q) : shifted[31:0];
            quo_d = {quo_q[30:0], ge};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: MIPS-style HI/LO multiply/divide unit controller.
//   clk, resetn : clock, async active-low reset
//   bus (slave) : start_valid/op/src_a/src_b/flush in;
//                 stall_o/hilo_we/hi_o/lo_o/busy_o/state_dbg out
// MULT/MULTU stay in MUL for MUL_CYCLES cycles; DIV/DIVU run 32 divider
// iterations in DIV. DONE presents the result with a one-cycle hilo_we.
// Signed division works on magnitudes; the quotient is negated when the
// operand signs differ and the remainder takes the dividend's sign.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic     clk,
    input  logic     resetn,
    muldiv_if.slave  bus
);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    muldiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic             acc_signed;
    logic             div_load;
    logic             div_en;
    logic [31:0]      div_quo;
    logic [31:0]      div_rem;
    logic             mul_signed;
    logic [63:0]      mul_a;
    logic [63:0]      mul_b;
    logic [63:0]      product;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             show_res;

    // op[0]=0 selects the signed flavour (MULT, DIV).
    assign acc_signed = ~bus.op[0];

    div_radix2 u_div (
        .clk       (clk),
        .resetn    (resetn),
        .load      (div_load),
        .en        (div_en),
        .dividend  (abs_if(bus.src_a, acc_signed)),
        .divisor   (abs_if(bus.src_b, acc_signed)),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Result datapath, purely from latched operands and divider state.
    always_comb begin
        mul_signed = ~op_q[0];
        // The low 64 bits of a product of sign-extended operands equal the
        // signed 64-bit product, so one multiplier serves both flavours.
        mul_a   = {{32{mul_signed & a_q[31]}}, a_q};
        mul_b   = {{32{mul_signed & b_q[31]}}, b_q};
        product = mul_a * mul_b;
        if (op_q[1]) begin
            res_hi = neg_if(div_rem, r_neg_q);
            res_lo = neg_if(div_quo, q_neg_q);
        end else begin
            res_hi = product[63:32];
            res_lo = product[31:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        div_load = 1'b0;
        div_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_valid && !bus.flush) begin
                    op_d    = bus.op;
                    a_d     = bus.src_a;
                    b_d     = bus.src_b;
                    q_neg_d = acc_signed & (bus.src_a[31] ^ bus.src_b[31]);
                    r_neg_d = acc_signed & bus.src_a[31];
                    cnt_d   = '0;
                    if (bus.op[1]) begin
                        state_d  = ST_DIV;
                        div_load = 1'b1;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == MUL_LAST) state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    div_en = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == DIV_LAST) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // start_valid is ignored here; the pipeline advances this cycle.
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    hi_d = res_hi;
                    lo_d = res_lo;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // A flush in DONE must drop the write and leave hi/lo showing the old
    // value, so the DONE presentation is gated by flush combinationally.
    assign show_res      = (state_q == ST_DONE) && !bus.flush;
    assign bus.hilo_we   = show_res;
    assign bus.hi_o      = show_res ? res_hi : hi_q;
    assign bus.lo_o      = show_res ? res_lo : lo_q;
    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.state_dbg = state_q;

    // resetn gates stall_o so it drops immediately, before the state flop
    // has visibly reset, even with start_valid still asserted.
    always_comb begin
        bus.stall_o = 1'b0;
        unique case (state_q)
            ST_IDLE: bus.stall_o = bus.start_valid & ~bus.flush;
            ST_MUL,
            ST_DIV:  bus.stall_o = ~bus.flush;
            default: bus.stall_o = 1'b0;
        endcase
        bus.stall_o = bus.stall_o & resetn;
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl (MUL_CYCLES=2).
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MUL_CYCLES = 2;

    logic clk;
    logic resetn;
    int   cyc;
    int   err_cnt;
    int   chk_cnt;

    logic [63:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [63:0] last_res;

    muldiv_if bus ();

    muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: independent arithmetic, 64-bit to avoid overflow cases.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  res = 64'(sa * sb);
            OP_MULTU: res = {32'h0, a} * {32'h0, b};
            OP_DIVU:  res = (b == 32'h0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 32'h0) begin
                    res = {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        int          c;
        #1;
        if (bus.hilo_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_hilo_we", bus.hilo_we, 1'b0);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("result_hi", bus.hi_o, e[63:32]);
                check("result_lo", bus.lo_o, e[31:0]);
                check("done_cycle", cyc, c);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic scramble();
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        bus.op    = 2'($urandom_range(0, 3));
    endtask

    // Issue one operation and follow it to completion.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int          t, lat;
        logic [63:0] e;
        @(negedge clk);
        t   = cyc;
        lat = op[1] ? (DIV_CYCLES + 1) : (MUL_CYCLES + 1);
        e   = model(op, a, b);
        bus.start_valid = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        exp_q.push_back(e);
        exp_cyc_q.push_back(t + lat);
        #1 check("stall_accept", bus.stall_o, 1'b1);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            scramble();
            #1 check("stall_busy", bus.stall_o, 1'b1);
        end
        @(negedge clk);
        #1 check("stall_done", bus.stall_o, 1'b0);
        // start_valid stayed high through DONE; it must not start a new op.
        @(negedge clk);
        bus.start_valid = 1'b0;
        #1;
        check("idle_after_done", bus.busy_o, 1'b0);
        check("hold_hi", bus.hi_o, e[63:32]);
        check("hold_lo", bus.lo_o, e[31:0]);
        last_res = e;
    endtask

    // DIVU cancelled by a flush flush_k cycles after acceptance.
    task automatic do_flushed_div(input logic [31:0] a, input logic [31:0] b, input int flush_k);
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.op    = OP_DIVU;
        bus.src_a = a;
        bus.src_b = b;
        for (int k = 1; k < flush_k; k++) begin
            @(negedge clk);
            scramble();
        end
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("flush_stall", bus.stall_o, 1'b0);
        check("flush_we", bus.hilo_we, 1'b0);
        @(negedge clk);
        bus.flush       = 1'b0;
        bus.start_valid = 1'b0;
        #1;
        check("flush_idle", bus.busy_o, 1'b0);
        check("flush_state", bus.state_dbg, ST_IDLE);
        check("flush_keep_hi", bus.hi_o, last_res[63:32]);
        check("flush_keep_lo", bus.lo_o, last_res[31:0]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        err_cnt = 0;
        chk_cnt = 0;
        last_res = '0;
        resetn = 1'b0;
        bus.start_valid = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.flush = 1'b0;

        repeat (2) @(negedge clk);
        bus.start_valid = 1'b1;
        #1;
        check("rst_stall", bus.stall_o, 1'b0);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_we", bus.hilo_we, 1'b0);
        check("rst_hi", bus.hi_o, 32'h0);
        check("rst_lo", bus.lo_o, 32'h0);
        check("rst_state", bus.state_dbg, ST_IDLE);
        @(negedge clk);
        bus.start_valid = 1'b0;
        resetn = 1'b1;

        // Directed vectors
        do_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005);
        do_op(OP_DIVU,  32'd100,       32'd7);
        do_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
        do_op(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE);
        do_op(OP_DIVU,  32'h1234_5678, 32'h0);
        do_op(OP_DIV,   32'hFFFF_FF00, 32'h0);
        do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(OP_MULT,  32'h8000_0000, 32'h8000_0000);

        // flush and start_valid together in IDLE: nothing accepted
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.op    = OP_MULT;
        bus.flush = 1'b1;
        #1 check("flush_vs_start_stall", bus.stall_o, 1'b0);
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.flush       = 1'b0;
        #1 check("flush_vs_start_busy", bus.busy_o, 1'b0);

        // DIVU flushed at T+10, then MULTU issued at T+12
        do_flushed_div(32'd1000, 32'd3, 10);
        do_op(OP_MULTU, 32'h0001_0000, 32'h0003_0001);

        // Random operations
        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            do_op(rop, ra, rb);
        end

        // Reset pulse at T+5 of a DIV
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.op    = OP_DIV;
        bus.src_a = 32'hFFFF_0000;
        bus.src_b = 32'd9;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_stall", bus.stall_o, 1'b0);
        check("arst_busy", bus.busy_o, 1'b0);
        check("arst_we", bus.hilo_we, 1'b0);
        check("arst_hi", bus.hi_o, 32'h0);
        check("arst_lo", bus.lo_o, 32'h0);
        @(negedge clk);
        bus.start_valid = 1'b0;
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("post_rst_idle", bus.busy_o, 1'b0);
        check("post_rst_hi", bus.hi_o, 32'h0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
